// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 slave (4-byte INCR bursts only) in front of a MEM_WORDS x 32-bit SRAM.
// Read and write channels are independent FSMs, each with one outstanding burst.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   s_axi_aw*                    write address (addr, id, len, valid/ready)
//   s_axi_w*                     write data (data, strb, last, valid/ready)
//   s_axi_b*                     write response (id, resp, valid/ready)
//   s_axi_ar*                    read address (addr, id, len, valid/ready)
//   s_axi_r*                     read data (data, resp, last, id, valid/ready)
module axi4_sram_slave #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [3:0]  s_axi_awid,
  input  logic [7:0]  s_axi_awlen,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [3:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [3:0]  s_axi_arid,
  input  logic [7:0]  s_axi_arlen,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        s_axi_rlast,
  output logic [3:0]  s_axi_rid
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  // Addresses are tracked as word addresses; byte offset bits are ignored (4-byte beats only).
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic in_range(input logic [29:0] wa);
    return wa < 30'(MEM_WORDS);
  endfunction

  logic [31:0] mem_q [MEM_WORDS];

  // ---------------- read channel ----------------
  rstate_e     rstate_q, rstate_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [7:0]  rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [29:0] raddr_q, raddr_d;
  logic [3:0]  rid_q, rid_d;
  logic        rvalid_q, rvalid_d, rlast_q, rlast_d, arready_q, arready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rload_c, rload_last_c;
  logic [29:0] rload_wa_c;

  // Read state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      rcnt_q    <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      raddr_q   <= '0;
      rid_q     <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      arready_q <= 1'b1;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      rcnt_q    <= rcnt_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      raddr_q   <= raddr_d;
      rid_q     <= rid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Read next-state
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE: if (s_axi_arvalid) rstate_d = (RD_LATENCY == 0) ? R_DATA : R_WAIT;
      R_WAIT: if (rcnt_q == 4'd1) rstate_d = R_DATA;
      R_DATA: if (s_axi_rready && rlast_q) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  // Read outputs: a "load" fetches the beat at rload_wa_c into the R registers
  always_comb begin
    rcnt_d       = rcnt_q;
    rlen_d       = rlen_q;
    rbeat_d      = rbeat_q;
    raddr_d      = raddr_q;
    rid_d        = rid_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rload_c      = 1'b0;
    rload_last_c = 1'b0;
    rload_wa_c   = raddr_q;
    case (rstate_q)
      R_IDLE: if (s_axi_arvalid) begin
        rid_d   = s_axi_arid;
        rlen_d  = s_axi_arlen;
        raddr_d = s_axi_araddr[31:2];
        rbeat_d = '0;
        rcnt_d  = 4'(RD_LATENCY);
        if (RD_LATENCY == 0) begin
          rload_c      = 1'b1;
          rload_wa_c   = s_axi_araddr[31:2];
          rload_last_c = (s_axi_arlen == 8'd0);
        end
      end
      R_WAIT: begin
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q == 4'd1) begin
          rload_c      = 1'b1;
          rload_last_c = (rlen_q == 8'd0);
        end
      end
      R_DATA: if (s_axi_rready) begin
        if (rlast_q) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          rdata_d  = '0;
          rresp_d  = 2'b00;
        end else begin
          raddr_d      = raddr_q + 30'd1;
          rbeat_d      = rbeat_q + 8'd1;
          rload_c      = 1'b1;
          rload_wa_c   = raddr_q + 30'd1;
          rload_last_c = ((rbeat_q + 8'd1) == rlen_q);
        end
      end
      default: ;
    endcase
    // Reads sample mem_q before this edge's write lands, giving read-before-write
    if (rload_c) begin
      rvalid_d = 1'b1;
      rlast_d  = rload_last_c;
      if (in_range(rload_wa_c)) begin
        rdata_d = mem_q[rload_wa_c[AW-1:0]];
        rresp_d = 2'b00;
      end else begin
        rdata_d = '0;
        rresp_d = 2'b10;
      end
    end
  end

  // ---------------- write channel ----------------
  wstate_e     wstate_q, wstate_d;
  logic [7:0]  wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [29:0] waddr_q, waddr_d;
  logic [3:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        bvalid_q, bvalid_d, werr_q, werr_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        we_c, wlast_beat_c, w_in_c, beat_err_c;

  // Write state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      waddr_q   <= '0;
      bid_q     <= '0;
      bresp_q   <= '0;
      bvalid_q  <= 1'b0;
      werr_q    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      waddr_q   <= waddr_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  // Burst length comes from awlen; wlast is only checked for consistency
  assign wlast_beat_c = (wbeat_q == wlen_q);
  assign w_in_c       = in_range(waddr_q);
  assign beat_err_c   = !w_in_c || (s_axi_wlast != wlast_beat_c);

  // Write next-state
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: if (s_axi_awvalid) wstate_d = W_DATA;
      W_DATA: if (s_axi_wvalid && wlast_beat_c) wstate_d = W_RESP;
      W_RESP: if (s_axi_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE);
    wready_d  = (wstate_d == W_DATA);
  end

  // Write outputs and memory enable
  always_comb begin
    wlen_d   = wlen_q;
    wbeat_d  = wbeat_q;
    waddr_d  = waddr_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    werr_d   = werr_q;
    we_c     = 1'b0;
    case (wstate_q)
      W_IDLE: if (s_axi_awvalid) begin
        bid_d   = s_axi_awid;
        wlen_d  = s_axi_awlen;
        waddr_d = s_axi_awaddr[31:2];
        wbeat_d = '0;
      end
      W_DATA: if (s_axi_wvalid) begin
        we_c   = w_in_c;
        werr_d = werr_q | beat_err_c;
        if (wlast_beat_c) begin
          bvalid_d = 1'b1;
          bresp_d  = (werr_q | beat_err_c) ? 2'b10 : 2'b00;
        end else begin
          waddr_d = waddr_q + 30'd1;
          wbeat_d = wbeat_q + 8'd1;
        end
      end
      W_RESP: if (s_axi_bready) begin
        bvalid_d = 1'b0;
        bresp_d  = 2'b00;
        werr_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // SRAM array, byte-enabled write, contents survive reset
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem_q[waddr_q[AW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave: randomized + directed bench for axi4_sram_slave against a byte-array model.
module tb_axi4_sram_slave;

  localparam int unsigned MEM_WORDS  = 64;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned MEM_BYTES  = MEM_WORDS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [3:0]  s_axi_awid;
  logic [7:0]  s_axi_awlen;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [3:0]  s_axi_arid;
  logic [7:0]  s_axi_arlen;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [3:0]  s_axi_rid;

  axi4_sram_slave #(.MEM_WORDS(MEM_WORDS), .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  logic [31:0] rcap [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (a < MEM_BYTES) return {ref_mem[a+32'd3], ref_mem[a+32'd2], ref_mem[a+32'd1], ref_mem[a]};
    return 32'h0;
  endfunction

  task automatic fill_wdata(input int n, input bit rand_strb);
    for (int i = 0; i < n; i++) begin
      wdat[i] = $urandom;
      wstb[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  endtask

  // wl_mode: 0 correct wlast, 1 wlast on beat 0 only, 2 wlast never asserted
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int wl_mode, input int b_stall, input bit gaps);
    logic [31:0] a;
    bit err;
    int n;
    err = 0;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awid = id; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; @(negedge clk); end
      s_axi_wdata = wdat[i];
      s_axi_wstrb = wstb[i];
      s_axi_wlast = (wl_mode == 1) ? (i == 0) : ((wl_mode == 2) ? 1'b0 : (i == len));
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("w_timeout", 32'd0, 32'd1);
      @(posedge clk);
      a = addr + 32'(4 * i);
      if (s_axi_wlast != (i == len)) err = 1;
      if (a < MEM_BYTES) begin
        for (int b = 0; b < 4; b++)
          if (wstb[i][b]) ref_mem[a + 32'(b)] = wdat[i][8*b +: 8];
      end else err = 1;
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    for (int k = 0; k < b_stall; k++) begin
      chk("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
      @(negedge clk);
    end
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    chk("bresp", 32'(s_axi_bresp), err ? 32'd2 : 32'd0);
    chk("bid", 32'(s_axi_bid), 32'(id));
    s_axi_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_axi_bready = 1'b0;
    chk("bvalid_clr", 32'(s_axi_bvalid), 32'd0);
    chk("awready_back", 32'(s_axi_awready), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input int stall_beat, input int stall_cyc);
    logic [31:0] a, hold_d;
    logic hold_l;
    int n;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arid = id; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 1;
    while (!s_axi_rvalid && n < 40) begin @(negedge clk); n++; end
    chk("r_latency", 32'(n), 32'(1 + RD_LATENCY));
    for (int i = 0; i <= len; i++) begin
      a = addr + 32'(4 * i);
      if (i == stall_beat) begin
        s_axi_rready = 1'b0;
        hold_d = s_axi_rdata;
        hold_l = s_axi_rlast;
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge clk);
          chk("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
          chk("r_hold_data", s_axi_rdata, hold_d);
          chk("r_hold_last", 32'(s_axi_rlast), 32'(hold_l));
        end
      end
      chk("rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("rdata", s_axi_rdata, exp_word(a));
      chk("rresp", 32'(s_axi_rresp), (a < MEM_BYTES) ? 32'd0 : 32'd2);
      chk("rlast", 32'(s_axi_rlast), 32'(i == len));
      chk("rid", 32'(s_axi_rid), 32'(id));
      rcap[i] = s_axi_rdata;
      s_axi_rready = 1'b1;
      @(posedge clk); @(negedge clk);
      s_axi_rready = 1'b0;
    end
    chk("rvalid_end", 32'(s_axi_rvalid), 32'd0);
    chk("arready_end", 32'(s_axi_arready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_arready"}, 32'(s_axi_arready), 32'd1);
    chk({pfx, "_awready"}, 32'(s_axi_awready), 32'd1);
    chk({pfx, "_wready"},  32'(s_axi_wready),  32'd0);
    chk({pfx, "_rvalid"},  32'(s_axi_rvalid),  32'd0);
    chk({pfx, "_rlast"},   32'(s_axi_rlast),   32'd0);
    chk({pfx, "_bvalid"},  32'(s_axi_bvalid),  32'd0);
    chk({pfx, "_rdata"},   s_axi_rdata,        32'd0);
    chk({pfx, "_rresp"},   32'(s_axi_rresp),   32'd0);
    chk({pfx, "_rid"},     32'(s_axi_rid),     32'd0);
    chk({pfx, "_bid"},     32'(s_axi_bid),     32'd0);
    chk({pfx, "_bresp"},   32'(s_axi_bresp),   32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int n, len;
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_awid = '0; s_axi_awlen = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_arid = '0;
    s_axi_arlen = '0; s_axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b0;

    // initialise every word so the model is fully known
    for (int blk = 0; blk < 4; blk++) begin
      fill_wdata(16, 1'b0);
      axi_write(32'(blk * 64), 15, 4'(blk), 0, 0, 1'b0);
    end

    // basic 4-beat write then read back
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'h11111111 * 32'(i + 1); wstb[i] = 4'hF; end
    axi_write(32'h10, 3, 4'h5, 0, 0, 1'b0);
    axi_read(32'h10, 3, 4'h6, -1, 0);
    chk("seq_beat0", rcap[0], 32'h11111111);
    chk("seq_beat3", rcap[3], 32'h44444444);

    // byte-strobe merge
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
    axi_write(32'h0, 0, 4'h1, 0, 0, 1'b0);
    wdat[0] = 32'h00000099; wstb[0] = 4'b0001;
    axi_write(32'h0, 0, 4'h2, 0, 0, 1'b0);
    axi_read(32'h0, 0, 4'h3, -1, 0);
    chk("strb_merge", rcap[0], 32'hAABBCC99);

    // read crossing the top of memory
    axi_read(32'(MEM_BYTES - 8), 3, 4'h7, -1, 0);
    chk("oor_beat2", rcap[2], 32'h0);

    // rready / bready back-pressure
    axi_read(32'h40, 3, 4'h8, 1, 5);
    fill_wdata(4, 1'b0);
    axi_write(32'h60, 3, 4'h9, 0, 4, 1'b0);

    // wlast protocol errors: data still written, bresp SLVERR
    fill_wdata(2, 1'b0);
    axi_write(32'h70, 1, 4'hA, 1, 0, 1'b0);
    axi_read(32'h70, 1, 4'hA, -1, 0);
    chk("early_wlast_b1", rcap[1], wdat[1]);
    fill_wdata(3, 1'b0);
    axi_write(32'h78, 2, 4'hB, 2, 0, 1'b0);

    // zero strobe, out-of-range tail, and 32-bit address wrap
    wdat[0] = $urandom; wstb[0] = 4'h0;
    axi_write(32'h24, 0, 4'hC, 0, 0, 1'b0);
    fill_wdata(3, 1'b0);
    axi_write(32'(MEM_BYTES - 4), 2, 4'hD, 0, 0, 1'b0);
    fill_wdata(4, 1'b0);
    axi_write(32'hFFFF_FFF8, 3, 4'hE, 0, 0, 1'b0);
    axi_read(32'hFFFF_FFF8, 3, 4'hF, -1, 0);

    // reset in the middle of a read burst
    @(negedge clk);
    s_axi_araddr = 32'h20; s_axi_arlen = 8'd7; s_axi_arid = 4'h9; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 40) begin @(negedge clk); n++; end
    s_axi_rready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_axi_rready = 1'b0;
    chk("pre_rst_rvalid", 32'(s_axi_rvalid), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    axi_read(32'h28, 1, 4'h4, -1, 0);

    // concurrent write and read on disjoint regions
    fill_wdata(8, 1'b1);
    fork
      axi_write(32'h80, 7, 4'h3, 0, 2, 1'b1);
      axi_read(32'h00, 7, 4'h5, 2, 3);
    join
    axi_read(32'h80, 7, 4'h6, -1, 0);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      else a = 32'(4 * $urandom_range(0, MEM_WORDS + 4));
      if ($urandom_range(0, 1) == 0) begin
        fill_wdata(len + 1, 1'b1);
        axi_write(a, len, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 2)) : 0,
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else begin
        axi_read(a, len, 4'($urandom_range(0, 15)), $urandom_range(0, 8), $urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
